// File: rtl/boid_frame_writer.sv
// rtl/boid_frame_writer.sv - per-frame boid scan that clears the display RAM and emits clipped pixel writes
module boid_frame_writer #(
   parameter int NUM_BOIDS = 128,
   parameter int IDX_W     = $clog2(NUM_BOIDS),
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int ADDR_W    = 19,
   parameter int DIV_W     = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic [IDX_W-1:0]  cpu_idx,
   input  logic [X_W-1:0]    cpu_x,
   input  logic [Y_W-1:0]    cpu_y,
   input  logic              frame_end,
   input  logic [DIV_W-1:0]  refresh_div,
   input  logic              freeze,
   input  logic              sprite_2x2,
   output logic              ram_clear,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              busy,
   output logic [7:0]        overrun_count
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN} state_t;

   state_t               state, state_next;
   logic [X_W+Y_W-1:0]   pos [NUM_BOIDS];
   logic [DIV_W-1:0]     div_cnt;
   logic [IDX_W-1:0]     idx;
   logic [1:0]           sub;
   logic                 spr_q;
   logic                 last_q;
   logic                 trigger;
   logic                 fetch;
   logic                 mode_2x2;
   logic                 last_pair;
   logic [X_W-1:0]       bx;
   logic [Y_W-1:0]       by;
   logic [X_W:0]         px;
   logic [Y_W:0]         py;
   logic [31:0]          addr_full;
   logic                 in_range;

   // The CLEAR cycle already fetches pair (0,0) so the first write lands right after ram_clear.
   assign trigger   = (state == S_IDLE) && frame_end && !freeze && (div_cnt == refresh_div);
   assign fetch     = (state == S_CLEAR) || ((state == S_SCAN) && !last_q);
   assign mode_2x2  = (state == S_CLEAR) ? sprite_2x2 : spr_q;
   assign {bx, by}  = pos[idx];
   assign px        = {1'b0, bx} + {{X_W{1'b0}}, sub[0]};
   assign py        = {1'b0, by} + {{Y_W{1'b0}}, sub[1]};
   assign in_range  = (32'(px) < 32'(SCREEN_W)) && (32'(py) < 32'(SCREEN_H));
   assign addr_full = 32'(px) + 32'(SCREEN_W) * 32'(py);
   assign last_pair = (32'(idx) == 32'(NUM_BOIDS - 1)) && (!mode_2x2 || (sub == 2'd3));

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (trigger) state_next = S_CLEAR;
         S_CLEAR: state_next = S_SCAN;
         S_SCAN:  if (last_q) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ram_clear = (state == S_CLEAR);
      busy      = (state != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_BOIDS; i++) pos[i] <= '0;
      end else if (cpu_we && (32'(cpu_idx) < 32'(NUM_BOIDS))) begin
         pos[cpu_idx] <= {cpu_x, cpu_y};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt       <= '0;
         idx           <= '0;
         sub           <= '0;
         spr_q         <= 1'b0;
         last_q        <= 1'b0;
         ram_we        <= 1'b0;
         ram_addr      <= '0;
         overrun_count <= '0;
      end else begin
         if ((state == S_IDLE) && frame_end && !freeze)
            div_cnt <= (div_cnt == refresh_div) ? '0 : div_cnt + 1'b1;
         if ((state != S_IDLE) && frame_end && (overrun_count != 8'hFF))
            overrun_count <= overrun_count + 8'd1;
         if (state == S_CLEAR)
            spr_q <= sprite_2x2;
         if (fetch) begin
            ram_we <= in_range;
            if (in_range) ram_addr <= addr_full[ADDR_W-1:0];
            last_q <= last_pair;
            if (mode_2x2 && (sub != 2'd3)) begin
               sub <= sub + 2'd1;
            end else begin
               sub <= '0;
               idx <= idx + 1'b1;
            end
         end else begin
            ram_we <= 1'b0;
            last_q <= 1'b0;
            idx    <= '0;
            sub    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_boid_frame_writer.sv
// tb/tb_boid_frame_writer.sv - directed bench for boid_frame_writer (128 and 100 entry instances)
module tb_boid_frame_writer;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_we, cpu_we2;
   logic [6:0]  cpu_idx;
   logic [9:0]  cpu_x;
   logic [8:0]  cpu_y;
   logic        frame_end, frame_end2;
   logic [4:0]  refresh_div;
   logic        freeze;
   logic        sprite_2x2;
   logic        ram_clear, ram_we, busy;
   logic [18:0] ram_addr;
   logic [7:0]  overrun_count;
   logic        ram_clear2, ram_we2, busy2;
   logic [18:0] ram_addr2;
   logic [7:0]  overrun_count2;

   int checks = 0;
   int passed = 0;

   always #5 clock = ~clock;

   boid_frame_writer dut (
      .clock(clock), .reset(reset), .cpu_we(cpu_we), .cpu_idx(cpu_idx),
      .cpu_x(cpu_x), .cpu_y(cpu_y), .frame_end(frame_end), .refresh_div(refresh_div),
      .freeze(freeze), .sprite_2x2(sprite_2x2), .ram_clear(ram_clear), .ram_we(ram_we),
      .ram_addr(ram_addr), .busy(busy), .overrun_count(overrun_count)
   );

   boid_frame_writer #(.NUM_BOIDS(100)) dut100 (
      .clock(clock), .reset(reset), .cpu_we(cpu_we2), .cpu_idx(cpu_idx),
      .cpu_x(cpu_x), .cpu_y(cpu_y), .frame_end(frame_end2), .refresh_div(refresh_div),
      .freeze(freeze), .sprite_2x2(sprite_2x2), .ram_clear(ram_clear2), .ram_we(ram_we2),
      .ram_addr(ram_addr2), .busy(busy2), .overrun_count(overrun_count2)
   );

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic write_boid(input bit sel, input int i, input int x, input int y);
      @(negedge clock);
      cpu_idx = 7'(i);
      cpu_x   = 10'(x);
      cpu_y   = 9'(y);
      if (sel) cpu_we2 = 1'b1;
      else     cpu_we  = 1'b1;
      @(negedge clock);
      cpu_we  = 1'b0;
      cpu_we2 = 1'b0;
   endtask

   task automatic fire(input bit sel);
      @(negedge clock);
      if (sel) frame_end2 = 1'b1;
      else     frame_end  = 1'b1;
      @(negedge clock);
      frame_end  = 1'b0;
      frame_end2 = 1'b0;
   endtask

   // Called in the cycle after the triggering edge; walks until busy drops.
   // mode 1 drops one pulse at k=50, mode 2 pulses on every odd cycle.
   task automatic capture(input bit sel, input int mode,
                          output int busy_cyc, output int we_cnt, output int clr_cnt,
                          output int zero_cnt, output logic first_we,
                          output logic [18:0] first_addr, output logic [18:0] last_addr,
                          output bit timed_out);
      logic b, c, w;
      logic [18:0] a;
      busy_cyc = 0; we_cnt = 0; clr_cnt = 0; zero_cnt = 0;
      first_we = 1'b0; first_addr = '0; last_addr = '0; timed_out = 1'b0;
      for (int k = 0; k < 700; k++) begin
         b = sel ? busy2 : busy;
         c = sel ? ram_clear2 : ram_clear;
         w = sel ? ram_we2 : ram_we;
         a = sel ? ram_addr2 : ram_addr;
         if (!b) break;
         busy_cyc++;
         if (c) clr_cnt++;
         if (w) begin
            we_cnt++;
            if (a == 19'd0) zero_cnt++;
            last_addr = a;
         end
         if (k == 1) begin
            first_we   = w;
            first_addr = a;
         end
         if ((mode == 1 && k == 50) || (mode == 2 && (k % 2) == 1)) begin
            if (sel) frame_end2 = 1'b1;
            else     frame_end  = 1'b1;
         end
         @(negedge clock);
         frame_end  = 1'b0;
         frame_end2 = 1'b0;
         if (k == 699) timed_out = 1'b1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({ram_clear, ram_we, busy} !== 3'b000) $display("FAIL reset_ctrl got %b exp 000", {ram_clear, ram_we, busy}); else passed++;
      checks++; if (ram_addr !== 19'd0) $display("FAIL reset_addr got %0d exp 0", ram_addr); else passed++;
      checks++; if (overrun_count !== 8'd0) $display("FAIL reset_overrun got %0d exp 0", overrun_count); else passed++;
      checks++; if ({ram_clear2, ram_we2, busy2, ram_addr2, overrun_count2} !== '0) $display("FAIL reset_dut100 got nonzero outputs exp 0"); else passed++;
   endtask

   task automatic test_single_scan();
      int bc, wc, cc, zc; logic fw; logic [18:0] fa, la; bit to;
      refresh_div = 5'd0;
      write_boid(0, 0, 10, 2);
      fire(0);
      capture(0, 0, bc, wc, cc, zc, fw, fa, la, to);
      checks++; if (to) $display("FAIL single_timeout got busy stuck exp release"); else passed++;
      checks++; if (cc !== 1) $display("FAIL single_clear got %0d exp 1", cc); else passed++;
      checks++; if (fw !== 1'b1 || fa !== 19'd1290) $display("FAIL single_first got we=%b addr=%0d exp we=1 addr=1290", fw, fa); else passed++;
      checks++; if (wc !== 128 || zc !== 127) $display("FAIL single_writes got %0d/%0d exp 128/127", wc, zc); else passed++;
      checks++; if (bc !== 129) $display("FAIL single_busy got %0d exp 129", bc); else passed++;
      checks++; if (busy !== 1'b0 || ram_we !== 1'b0) $display("FAIL single_after got busy=%b we=%b exp 0 0", busy, ram_we); else passed++;
   endtask

   task automatic test_divider();
      int bc, wc, cc, zc; logic fw; logic [18:0] fa, la; bit to;
      refresh_div = 5'd3;
      for (int p = 1; p <= 8; p++) begin
         fire(0);
         capture(0, 0, bc, wc, cc, zc, fw, fa, la, to);
         checks++;
         if (cc !== ((p == 4 || p == 8) ? 1 : 0)) $display("FAIL divider_pulse%0d got %0d clears exp %0d", p, cc, (p == 4 || p == 8) ? 1 : 0);
         else passed++;
         repeat (150) @(negedge clock);
      end
      refresh_div = 5'd0;
   endtask

   task automatic test_sprite_clip();
      int bc, wc, cc, zc; logic fw; logic [18:0] fa, la; bit to;
      for (int i = 0; i < 128; i++) begin
         if (i == 5) write_boid(0, i, 639, 479);
         else        write_boid(0, i, 700, 0);
      end
      sprite_2x2 = 1'b1;
      fire(0);
      capture(0, 0, bc, wc, cc, zc, fw, fa, la, to);
      sprite_2x2 = 1'b0;
      checks++; if (wc !== 1 || la !== 19'd307199) $display("FAIL sprite_write got %0d writes last=%0d exp 1 at 307199", wc, la); else passed++;
      checks++; if (bc !== 513) $display("FAIL sprite_busy got %0d exp 513", bc); else passed++;
   endtask

   task automatic test_overrun();
      int bc, wc, cc, zc; logic fw; logic [18:0] fa, la; bit to;
      fire(0);
      capture(0, 1, bc, wc, cc, zc, fw, fa, la, to);
      checks++; if (cc !== 1) $display("FAIL overrun_clear got %0d exp 1", cc); else passed++;
      checks++; if (bc !== 129) $display("FAIL overrun_busy got %0d exp 129", bc); else passed++;
      checks++; if (overrun_count !== 8'd1) $display("FAIL overrun_one got %0d exp 1", overrun_count); else passed++;
      repeat (5) @(negedge clock);
      checks++; if (busy !== 1'b0) $display("FAIL overrun_norestart got busy=%b exp 0", busy); else passed++;
      sprite_2x2 = 1'b1;
      fire(0);
      capture(0, 2, bc, wc, cc, zc, fw, fa, la, to);
      sprite_2x2 = 1'b0;
      checks++; if (overrun_count !== 8'd255) $display("FAIL overrun_saturate got %0d exp 255", overrun_count); else passed++;
      checks++; if (bc !== 513) $display("FAIL overrun_busy2x2 got %0d exp 513", bc); else passed++;
   endtask

   task automatic test_freeze();
      int bc, wc, cc, zc; logic fw; logic [18:0] fa, la; bit to;
      refresh_div = 5'd1;
      freeze = 1'b1;
      fire(0);
      capture(0, 0, bc, wc, cc, zc, fw, fa, la, to);
      checks++; if (bc !== 0) $display("FAIL freeze_ignored got %0d busy cycles exp 0", bc); else passed++;
      freeze = 1'b0;
      fire(0);
      capture(0, 0, bc, wc, cc, zc, fw, fa, la, to);
      checks++; if (bc !== 0) $display("FAIL freeze_divhold got %0d busy cycles exp 0", bc); else passed++;
      fire(0);
      capture(0, 0, bc, wc, cc, zc, fw, fa, la, to);
      checks++; if (cc !== 1 || bc !== 129) $display("FAIL freeze_resume got clr=%0d busy=%0d exp 1 129", cc, bc); else passed++;
      refresh_div = 5'd0;
   endtask

   task automatic test_small_instance();
      int bc, wc, cc, zc; logic fw; logic [18:0] fa, la; bit to;
      write_boid(1, 110, 5, 5);
      write_boid(1, 99, 3, 1);
      fire(1);
      capture(1, 0, bc, wc, cc, zc, fw, fa, la, to);
      checks++; if (bc !== 101) $display("FAIL small_busy got %0d exp 101", bc); else passed++;
      checks++; if (wc !== 100 || zc !== 99) $display("FAIL small_writes got %0d/%0d exp 100/99", wc, zc); else passed++;
      checks++; if (la !== 19'd643) $display("FAIL small_last got %0d exp 643", la); else passed++;
   endtask

   task automatic test_reset_mid_scan();
      int bc, wc, cc, zc; logic fw; logic [18:0] fa, la; bit to;
      fire(0);
      repeat (41) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++; if (ram_we !== 1'b0 || busy !== 1'b0 || ram_clear !== 1'b0) $display("FAIL midreset_outputs got we=%b busy=%b clr=%b exp 0 0 0", ram_we, busy, ram_clear); else passed++;
      checks++; if (overrun_count !== 8'd0) $display("FAIL midreset_overrun got %0d exp 0", overrun_count); else passed++;
      fire(0);
      capture(0, 0, bc, wc, cc, zc, fw, fa, la, to);
      checks++; if (wc !== 128 || zc !== 128) $display("FAIL midreset_table got %0d/%0d exp 128/128", wc, zc); else passed++;
      checks++; if (bc !== 129) $display("FAIL midreset_busy got %0d exp 129", bc); else passed++;
   endtask

   initial begin
      reset = 1'b1; cpu_we = 1'b0; cpu_we2 = 1'b0; cpu_idx = '0; cpu_x = '0; cpu_y = '0;
      frame_end = 1'b0; frame_end2 = 1'b0; refresh_div = '0; freeze = 1'b0; sprite_2x2 = 1'b0;
      test_reset();
      test_single_scan();
      test_divider();
      test_sprite_clip();
      test_overrun();
      test_freeze();
      test_small_instance();
      test_reset_mid_scan();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/boid_frame_writer.md
Name:
boid_frame_writer

Overview:
Parametrised successor to the per-frame boid display update sequencer. It holds a CPU-writable table of boid positions. On a qualified frame-end pulse it issues a one-cycle display-RAM clear/swap pulse, then scans every boid and emits pixel write commands (address = x + SCREEN_W*y) to the 1-bit boid display RAM. New capabilities:
- configurable NUM_BOIDS (not limited to 32);
- frame-rate divider;
- 1x1 or 2x2 sprite mode;
- off-screen clipping;
- freeze;
- overrun counting.

Parameters:
NUM_BOIDS, 128, number of boid position entries
IDX_W, $clog2(NUM_BOIDS), boid index width
X_W, 10, x coordinate width
Y_W, 9, y coordinate width
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
ADDR_W, 19, display RAM address width
DIV_W, 5, refresh divider width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_we  in  1  write cpu_x/cpu_y into entry cpu_idx
cpu_idx  in  IDX_W  boid index to write
cpu_x  in  X_W  boid x
cpu_y  in  Y_W  boid y
frame_end  in  1  one-cycle frame-end pulse, already in clock domain
refresh_div  in  DIV_W  redraw every refresh_div+1 qualified frames
freeze  in  1  1 = ignore frame_end while idle
sprite_2x2  in  1  1 = draw each boid as 2x2 pixels
ram_clear  out  1  one-cycle clear/swap pulse to display RAM
ram_we  out  1  display RAM pixel write enable (data is implicitly 1)
ram_addr  out  ADDR_W  display RAM write address
busy  out  1  clear/scan in progress
overrun_count  out  8  saturating count of frame_end pulses dropped while busy

Behaviour:
- One clock, named clock; reset is synchronous and active-high, named reset.
- Reset values:
  - all outputs 0;
  - position table all (0,0);
  - divider count 0;
  - state IDLE.
- Reset mid-scan: outputs 0 from the next edge; scan is abandoned with no further writes.
- Position table:
  - On cpu_we, entry cpu_idx <= {cpu_x, cpu_y}.
  - If cpu_idx >= NUM_BOIDS, the write is ignored.
  - A write during a scan is allowed. A write and a scan read of the same entry in the same cycle returns the old value.
- State IDLE, on a frame_end edge:
  - freeze=1: no action; divider unchanged.
  - Else if div_cnt == refresh_div: div_cnt <= 0 and go to CLEAR.
  - Else: div_cnt <= div_cnt + 1.
- State CLEAR (1 cycle):
  - ram_clear=1 and busy=1 in the cycle following the triggering frame_end edge.
  - idx <= 0, sub <= 0.
  - sprite_2x2 is latched here for the whole scan.
  - Next state: SCAN.
- State SCAN:
  - Each cycle processes one (idx, sub) pair; the registered ram_we/ram_addr appear one cycle later.
  - The first write slot is the cycle immediately after ram_clear.
  - Pixel for sub 0..3 = (x+sub[0], y+sub[1]). In 1x1 mode only sub=0 is used.
  - A pixel is emitted only if px < SCREEN_W and py < SCREEN_H. A clipped slot keeps ram_we=0 and still consumes its cycle.
  - ram_addr = px + SCREEN_W*py, computed at full width then truncated to ADDR_W. The in-range maximum is 307199.
  - Advance order: sub first, then idx.
  - After idx = NUM_BOIDS-1 with the last sub, return to IDLE.
- Scan timing:
  - Scan length is exactly NUM_BOIDS (1x1) or 4*NUM_BOIDS (2x2) write slots.
  - busy is high from the ram_clear cycle through the last write slot inclusive, i.e. 1+NUM_BOIDS or 1+4*NUM_BOIDS cycles.
- Overrun:
  - frame_end while busy (CLEAR or SCAN) is dropped and overrun_count increments, saturating at 255.
  - The divider is not advanced.
  - freeze does not suppress overrun counting.
- freeze asserted mid-scan: the scan completes normally.
- frame_end coincident with the last write slot counts as overrun. frame_end in the first IDLE cycle is accepted.

Test Plan:
1. Reset, write boid 0 = (10,2), refresh_div=0, one frame_end → ram_clear high 1 cycle; next cycle ram_we=1, ram_addr=1290; then 127 writes to addr 0; busy high 129 cycles; then busy=0.
2. refresh_div=3, four frame_end pulses spaced 2000 cycles apart → ram_clear only after the 4th; a 5th pulse does not trigger; the 8th does.
3. sprite_2x2=1, boid 5 = (639,479), all others (700,0) → exactly one ram_we in the scan, addr 307199; busy high 513 cycles.
4. frame_end pulse 50 cycles into a scan → no second ram_clear, overrun_count=1, scan length unchanged; 300 such drops → overrun_count stays at 255.
5. freeze=1 plus frame_end → no ram_clear, div_cnt unchanged. Instance with NUM_BOIDS=100: cpu_we at idx 110 → no entry changes, and a scan emits 100 slots.
6. Assert reset while the scan is at idx 40 → ram_we=0, busy=0 next cycle. The next frame_end scan writes addr 0 for all 128 slots (table cleared).
